// File: rtl/cu_pkg.sv
// cu_pkg: definitions shared by the CU-side ALU sharing logic.
//   ALU_ADD/ALU_SUB/ALU_MUL/ALU_DIV - ALUOP encodings understood by the ALU
//   arb_state_e                     - alu_arbiter FSM states
package cu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational 2-way request picker for alu_arbiter.
// Build option: ALU_ARBITER_ROUND_ROBIN_EN
//   defined   - on a tie, grant the requester that was not granted last
//   undefined - fixed priority, requester 0 wins every tie
// Ports:
//   valid0, valid1 - request pending from requester 0 / 1
//   last_grant     - index of the most recent grant
//   grant          - index of the chosen requester (only meaningful when
//                    at least one valid is high)
module alu_arb_pick
    import cu_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant
);

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = 1'b1;
        end
    end
`else
    // Fixed priority has no use for the history bit.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = 1'b0;
        if (!valid0 && valid1) begin
            grant = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one multi-cycle ALU between two requesters.
// Latches the winning request, issues a single ALU_Start pulse, waits for
// ALU_Done and hands the result back to the owner with a one-cycle Done.
// Build option: ALU_ARBITER_ROUND_ROBIN_EN selects round-robin tie breaking
// (default build is fixed priority, requester 0 first).
//
// Handshake: a requester raises ReqX_Valid with OP/A/B stable and holds
// them until it sees ReqX_Accept (one-cycle pulse), then drops Valid.
// Later, ReqX_Done pulses for one cycle with ReqX_Result valid; the result
// register holds until that requester's next Done. Towards the ALU the
// block drives ALUOP/ALU_A/ALU_B stable from ALU_Start until ALU_Done.
//
// Ports:
//   Clock, Reset                  - posedge clock, synchronous active-high reset
//   Req0_* / Req1_*               - requester Valid/OP/A/B in, Accept/Done/Result out
//   ALUOP, ALU_A, ALU_B, ALU_Start - request to the ALU (all registered)
//   ALU_Result, ALU_Done          - completion from the ALU
//   Busy                          - FSM not in IDLE
//   Err                           - sticky: ALU_Done seen outside WAIT
//   Dbg_State                     - current FSM state for observation
module alu_arbiter
    import cu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Req0_Valid,
    input  logic [OPW-1:0]   Req0_OP,
    input  logic [WIDTH-1:0] Req0_A,
    input  logic [WIDTH-1:0] Req0_B,
    input  logic             Req1_Valid,
    input  logic [OPW-1:0]   Req1_OP,
    input  logic [WIDTH-1:0] Req1_A,
    input  logic [WIDTH-1:0] Req1_B,
    output logic             Req0_Accept,
    output logic             Req1_Accept,
    output logic             Req0_Done,
    output logic             Req1_Done,
    output logic [WIDTH-1:0] Req0_Result,
    output logic [WIDTH-1:0] Req1_Result,
    output logic [OPW-1:0]   ALUOP,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic             ALU_Start,
    input  logic [WIDTH-1:0] ALU_Result,
    input  logic             ALU_Done,
    output logic             Busy,
    output logic             Err,
    output logic [1:0]       Dbg_State
);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             start_q, start_d;
    logic             acc0_q, acc0_d;
    logic             acc1_q, acc1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [WIDTH-1:0] res0_q, res0_d;
    logic [WIDTH-1:0] res1_q, res1_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             grant;

    alu_arb_pick u_pick (
        .valid0     (Req0_Valid),
        .valid1     (Req1_Valid),
        .last_grant (last_q),
        .grant      (grant)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        start_d = 1'b0;
        acc0_d  = 1'b0;
        acc1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        res0_d  = res0_q;
        res1_d  = res1_q;
        // A completion the FSM is not waiting for is never consumed as data.
        err_d   = err_q | (ALU_Done && (state_q != WAIT));

        unique case (state_q)
            IDLE: begin
                if (Req0_Valid || Req1_Valid) begin
                    state_d = ISSUE;
                    owner_d = grant;
                    last_d  = grant;
                    op_d    = grant ? Req1_OP : Req0_OP;
                    a_d     = grant ? Req1_A  : Req0_A;
                    b_d     = grant ? Req1_B  : Req0_B;
                    // Start/Accept are registered, so they appear during ISSUE.
                    start_d = 1'b1;
                    acc0_d  = ~grant;
                    acc1_d  = grant;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ALU_Done) begin
                    state_d = RESP;
                    if (owner_q) begin
                        res1_d  = ALU_Result;
                        done1_d = 1'b1;
                    end else begin
                        res0_d  = ALU_Result;
                        done0_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;   // so round-robin gives requester 0 the first tie
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            start_q <= 1'b0;
            acc0_q  <= 1'b0;
            acc1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            res0_q  <= '0;
            res1_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            start_q <= start_d;
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign ALUOP       = op_q;
    assign ALU_A       = a_q;
    assign ALU_B       = b_q;
    assign ALU_Start   = start_q;
    assign Req0_Accept = acc0_q;
    assign Req1_Accept = acc1_q;
    assign Req0_Done   = done0_q;
    assign Req1_Done   = done1_q;
    assign Req0_Result = res0_q;
    assign Req1_Result = res1_q;
    assign Busy        = busy_q;
    assign Err         = err_q;
    assign Dbg_State   = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter.
// Contains a latency-programmable ALU model, a high-level reference model
// of arbitration order and ALU arithmetic, a single-request vector table,
// hand-written multi-cycle sequences and randomized traffic.
module tb_alu_arbiter;
    import cu_pkg::*;

    localparam int W = 16;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } req_t;

    typedef struct packed {
        int           who;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        logic [W-1:0] exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         Req0_Valid = 1'b0, Req1_Valid = 1'b0;
    logic [1:0]   Req0_OP = '0, Req1_OP = '0;
    logic [W-1:0] Req0_A = '0, Req0_B = '0, Req1_A = '0, Req1_B = '0;
    logic         Req0_Accept, Req1_Accept, Req0_Done, Req1_Done;
    logic [W-1:0] Req0_Result, Req1_Result;
    logic [1:0]   ALUOP;
    logic [W-1:0] ALU_A, ALU_B;
    logic         ALU_Start;
    logic [W-1:0] ALU_Result;
    logic         ALU_Done;
    logic         Busy, Err;
    logic [1:0]   Dbg_State;

    always #5 Clock = ~Clock;

    alu_arbiter #(.WIDTH(W), .OPW(2)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Req0_Valid  (Req0_Valid),
        .Req0_OP     (Req0_OP),
        .Req0_A      (Req0_A),
        .Req0_B      (Req0_B),
        .Req1_Valid  (Req1_Valid),
        .Req1_OP     (Req1_OP),
        .Req1_A      (Req1_A),
        .Req1_B      (Req1_B),
        .Req0_Accept (Req0_Accept),
        .Req1_Accept (Req1_Accept),
        .Req0_Done   (Req0_Done),
        .Req1_Done   (Req1_Done),
        .Req0_Result (Req0_Result),
        .Req1_Result (Req1_Result),
        .ALUOP       (ALUOP),
        .ALU_A       (ALU_A),
        .ALU_B       (ALU_B),
        .ALU_Start   (ALU_Start),
        .ALU_Result  (ALU_Result),
        .ALU_Done    (ALU_Done),
        .Busy        (Busy),
        .Err         (Err),
        .Dbg_State   (Dbg_State)
    );

    // ---------------- bookkeeping ----------------
    int           n_tests = 0;
    int           n_fail  = 0;
    req_t         rq0[$];
    req_t         rq1[$];
    bit           model_last;
    logic [W-1:0] exp_res0, exp_res1;
    bit           err_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [31:0] aa, bb, r;
        aa = {16'b0, a};
        bb = {16'b0, b};
        case (op)
            ALU_ADD: r = aa + bb;
            ALU_SUB: r = aa - bb;
            ALU_MUL: r = aa * bb;
            default: r = (bb == 0) ? 32'hFFFF : aa / bb;
        endcase
        return r[W-1:0];
    endfunction

    function automatic req_t mk_req(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.exp = exp;
        return r;
    endfunction

    function automatic req_t mk_rand();
        logic [1:0]   op;
        logic [W-1:0] a, b;
        op = 2'($urandom_range(0, 3));
        a  = 16'($urandom);
        b  = 16'($urandom);
        if (op == ALU_DIV && b == 0) b = 16'd1;
        return mk_req(op, a, b, ref_alu(op, a, b));
    endfunction

    // ---------------- ALU model ----------------
    // Done arrives alu_lat cycles after the Start cycle; the result bus
    // carries junk whenever Done is low.
    int           alu_lat = 1;
    int           alu_cnt = 0;
    logic         alu_done_m = 1'b0;
    logic         inj_done = 1'b0;
    logic [W-1:0] alu_res_m = '0;
    logic [W-1:0] alu_pend = '0;
    logic         s_start, s_rst;
    logic [1:0]   s_op;
    logic [W-1:0] s_a, s_b;

    assign ALU_Done   = alu_done_m | inj_done;
    assign ALU_Result = alu_res_m;

    always begin
        @(negedge Clock);
        s_start = ALU_Start; s_rst = Reset; s_op = ALUOP; s_a = ALU_A; s_b = ALU_B;
        @(posedge Clock);
        #1;
        alu_done_m = 1'b0;
        alu_res_m  = 16'($urandom);
        if (s_rst) begin
            alu_cnt = 0;
        end else if (s_start) begin
            alu_pend = ref_alu(s_op, s_a, s_b);
            if (alu_lat <= 1) begin
                alu_done_m = 1'b1; alu_res_m = alu_pend;
            end else begin
                alu_cnt = alu_lat - 1;
            end
        end else if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                alu_done_m = 1'b1; alu_res_m = alu_pend;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        Reset = 1'b1; Req0_Valid = 1'b0; Req1_Valid = 1'b0; inj_done = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_last = 1'b1; exp_res0 = '0; exp_res1 = '0; err_exp = 1'b0;
    endtask

    // Present the head of a requester's queue, or withdraw with junk operands.
    task automatic raise(input int who);
        if (who == 0) begin
            if (rq0.size() > 0) begin
                Req0_Valid = 1'b1; Req0_OP = rq0[0].op; Req0_A = rq0[0].a; Req0_B = rq0[0].b;
            end else begin
                Req0_Valid = 1'b0; Req0_OP = 2'($urandom); Req0_A = 16'($urandom); Req0_B = 16'($urandom);
            end
        end else begin
            if (rq1.size() > 0) begin
                Req1_Valid = 1'b1; Req1_OP = rq1[0].op; Req1_A = rq1[0].a; Req1_B = rq1[0].b;
            end else begin
                Req1_Valid = 1'b0; Req1_OP = 2'($urandom); Req1_A = 16'($urandom); Req1_B = 16'($urandom);
            end
        end
    endtask

    task automatic drop(input int who);
        if (who == 0) begin
            Req0_Valid = 1'b0; Req0_OP = 2'($urandom); Req0_A = 16'($urandom); Req0_B = 16'($urandom);
        end else begin
            Req1_Valid = 1'b0; Req1_OP = 2'($urandom); Req1_A = 16'($urandom); Req1_B = 16'($urandom);
        end
    endtask

    // Serve everything queued in rq0/rq1. Each requester re-raises Valid at
    // its own Done if it has more work, so every arbitration sees exactly the
    // requesters with work left.
    task automatic run_engine(input int lat);
        int   order[$];
        int   n0, n1, g, grants, dones, starts, busy_cnt, owner, total, budget;
        bit   last, in_flight, unstable;
        logic [1:0]   h_op;
        logic [W-1:0] h_a, h_b;
        req_t r;

        n0 = rq0.size(); n1 = rq1.size(); last = model_last;
        while (n0 > 0 || n1 > 0) begin
            if (n0 > 0 && n1 > 0) g = RR ? (last ? 0 : 1) : 0;
            else                  g = (n0 > 0) ? 0 : 1;
            order.push_back(g);
            last = (g == 1);
            if (g == 0) n0--; else n1--;
        end
        total = order.size();
        budget = total * (lat + 8) + 16;

        alu_lat = lat; grants = 0; dones = 0; starts = 0; busy_cnt = 0; owner = 0;
        in_flight = 1'b0; unstable = 1'b0; h_op = '0; h_a = '0; h_b = '0;
        raise(0); raise(1);

        for (int cyc = 0; cyc < budget && dones < total; cyc++) begin
            @(posedge Clock);
            #1;
            if (ALU_Start) starts++;
            if (Req0_Accept || Req1_Accept) begin
                g = Req1_Accept ? 1 : 0;
                check("accept_onehot", 32'(Req0_Accept & Req1_Accept), 0);
                check("accept_owner", g, (grants < total) ? order[grants] : 2);
                if (grants == 0) check("accept_latency", cyc, 0);
                check("start_with_accept", 32'(ALU_Start), 1);
                if (g == 0) r = rq0[0]; else r = rq1[0];
                check("alu_op", 32'(ALUOP), 32'(r.op));
                check("alu_a", 32'(ALU_A), 32'(r.a));
                check("alu_b", 32'(ALU_B), 32'(r.b));
                h_op = ALUOP; h_a = ALU_A; h_b = ALU_B;
                in_flight = 1'b1; owner = g; busy_cnt = 0;
                drop(g);
                grants++;
            end else if (in_flight) begin
                if (ALUOP !== h_op || ALU_A !== h_a || ALU_B !== h_b) unstable = 1'b1;
            end
            if (Busy) busy_cnt++;
            if (Req0_Done || Req1_Done) begin
                g = Req1_Done ? 1 : 0;
                check("done_onehot", 32'(Req0_Done & Req1_Done), 0);
                check("done_in_flight", 32'(in_flight), 1);
                check("done_owner", g, owner);
                check("busy_cycles", busy_cnt, lat + 2);
                check("operands_stable", 32'(unstable), 0);
                if (g == 0) begin
                    check("req0_result", 32'(Req0_Result), 32'(rq0[0].exp));
                    check("req1_result_held", 32'(Req1_Result), 32'(exp_res1));
                    exp_res0 = rq0[0].exp;
                    void'(rq0.pop_front());
                end else begin
                    check("req1_result", 32'(Req1_Result), 32'(rq1[0].exp));
                    check("req0_result_held", 32'(Req0_Result), 32'(exp_res0));
                    exp_res1 = rq1[0].exp;
                    void'(rq1.pop_front());
                end
                in_flight = 1'b0; unstable = 1'b0;
                dones++;
                raise(g);
            end
        end

        check("all_done", dones, total);
        check("start_count", starts, total);
        @(posedge Clock);
        #1;
        check("idle_after_resp", 32'(Busy), 0);
        check("err_flag", 32'(Err), 32'(err_exp));
        model_last = last;
        rq0.delete(); rq1.delete();
        drop(0); drop(1);
        if (dones != total) do_reset();
    endtask

    // ---------------- scenarios ----------------
    vec_t tbl[9];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   seen, nd;
        logic [W-1:0] r0_before, r1_before;

        tbl[0] = '{0, ALU_ADD, 16'd5,      16'd7,      1, 16'd12};
        tbl[1] = '{1, ALU_SUB, 16'd9,      16'd4,      1, 16'd5};
        tbl[2] = '{0, ALU_MUL, 16'd3,      16'd6,      2, 16'd18};
        tbl[3] = '{1, ALU_DIV, 16'd35,     16'd5,      5, 16'd7};
        tbl[4] = '{0, ALU_SUB, 16'd3,      16'd5,      1, 16'hFFFE};
        tbl[5] = '{1, ALU_ADD, 16'hFFFF,   16'd1,      3, 16'd0};
        tbl[6] = '{0, ALU_MUL, 16'h0100,   16'h0100,   1, 16'd0};
        tbl[7] = '{1, ALU_DIV, 16'd100,    16'd7,      2, 16'd14};
        tbl[8] = '{0, ALU_MUL, 16'h00FF,   16'h0101,   1, 16'hFFFF};

        do_reset();

        // Reset state of every output.
        check("rst_state", 32'(Dbg_State), 32'(IDLE));
        check("rst_aluop", 32'(ALUOP), 0);
        check("rst_alu_a", 32'(ALU_A), 0);
        check("rst_alu_b", 32'(ALU_B), 0);
        check("rst_start", 32'(ALU_Start), 0);
        check("rst_accepts", 32'({Req0_Accept, Req1_Accept}), 0);
        check("rst_dones", 32'({Req0_Done, Req1_Done}), 0);
        check("rst_res0", 32'(Req0_Result), 0);
        check("rst_res1", 32'(Req1_Result), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_err", 32'(Err), 0);

        // Single requests from the vector table.
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].who == 0) rq0.push_back(mk_req(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp));
            else                 rq1.push_back(mk_req(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp));
            run_engine(tbl[i].lat);
        end

        // Simultaneous pair straight after reset.
        do_reset();
        rq0.push_back(mk_req(ALU_SUB, 16'd9, 16'd4, 16'd5));
        rq1.push_back(mk_req(ALU_MUL, 16'd3, 16'd6, 16'd18));
        run_engine(1);

        // Tie after a lone Req0 grant: round-robin favours Req1 here.
        do_reset();
        rq0.push_back(mk_req(ALU_ADD, 16'd1, 16'd2, 16'd3));
        run_engine(1);
        rq0.push_back(mk_req(ALU_ADD, 16'd4, 16'd4, 16'd8));
        rq1.push_back(mk_req(ALU_SUB, 16'd8, 16'd1, 16'd7));
        run_engine(2);

        // Continuous contention: fixed priority starves Req1, RR alternates.
        do_reset();
        for (int i = 0; i < 5; i++) rq0.push_back(mk_rand());
        for (int i = 0; i < 3; i++) rq1.push_back(mk_rand());
        run_engine(1);

        // Reset while waiting on a slow ALU.
        do_reset();
        rq0.push_back(mk_req(ALU_ADD, 16'd20, 16'd22, 16'd42));
        run_engine(1);
        alu_lat = 5;
        Req0_Valid = 1'b1; Req0_OP = ALU_ADD; Req0_A = 16'd1; Req0_B = 16'd2;
        seen = 0;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            @(posedge Clock);
            #1;
            if (Req0_Accept) seen = 1;
        end
        check("rstw_accept", seen, 1);
        drop(0);
        repeat (2) @(posedge Clock);
        #1;
        check("rstw_busy_in_wait", 32'(Busy), 1);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        check("rstw_state", 32'(Dbg_State), 32'(IDLE));
        check("rstw_alu_bus", 32'({ALUOP, ALU_A, ALU_B, ALU_Start}), 0);
        check("rstw_handshake", 32'({Req0_Accept, Req1_Accept, Req0_Done, Req1_Done}), 0);
        check("rstw_res0", 32'(Req0_Result), 0);
        check("rstw_res1", 32'(Req1_Result), 0);
        check("rstw_busy_err", 32'({Busy, Err}), 0);
        model_last = 1'b1; exp_res0 = '0; exp_res1 = '0; err_exp = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clock);
            #1;
            if (Req0_Done || Req1_Done) nd++;
        end
        check("rstw_no_done", nd, 0);
        rq0.push_back(mk_req(ALU_ADD, 16'd1, 16'd1, 16'd2));
        run_engine(1);

        // Stray ALU_Done in IDLE sets a sticky Err.
        do_reset();
        rq0.push_back(mk_req(ALU_ADD, 16'd2, 16'd3, 16'd5));
        run_engine(1);
        r0_before = exp_res0; r1_before = exp_res1;
        inj_done = 1'b1;
        @(posedge Clock);
        #1;
        inj_done = 1'b0;
        check("err_set", 32'(Err), 1);
        check("err_no_done", 32'({Req0_Done, Req1_Done}), 0);
        check("err_busy", 32'(Busy), 0);
        err_exp = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("err_sticky", 32'(Err), 1);
        check("err_res0_kept", 32'(Req0_Result), 32'(r0_before));
        check("err_res1_kept", 32'(Req1_Result), 32'(r1_before));
        rq1.push_back(mk_req(ALU_SUB, 16'd10, 16'd3, 16'd7));
        run_engine(2);
        do_reset();
        check("err_cleared", 32'(Err), 0);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 30; it++) begin
            int k0, k1;
            k0 = $urandom_range(0, 2);
            k1 = $urandom_range(0, 2);
            if (k0 + k1 == 0) k0 = 1;
            for (int j = 0; j < k0; j++) rq0.push_back(mk_rand());
            for (int j = 0; j < k1; j++) rq1.push_back(mk_rand());
            run_engine($urandom_range(1, 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
